alu_control_fsm: RTL and testbench

ALU_CONTROL_FSM -- requirements
Module: alu_control_fsm

---
 rtl/alu_control_fsm.sv | 162 ++++++++++++++++
 tb/tb_alu_control_fsm.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_fsm.sv
// rtl/alu_control_fsm.sv - instruction sequencer driving ALU controls and register-file strobes
//
// Accepts one 24-bit instruction at a time and steps it through
// DECODE -> EXECUTE -> WRITEBACK before returning to IDLE.
//
// Ports:
//   Clock       in   single clock, rising edge
//   Reset       in   synchronous, active-high
//   InstrValid  in   upstream instruction valid
//   Instr       in   [23:20] opcode, [19:16] rs, [15:12] rt, [11:8] rd, [7:0] imm
//   Stall       in   holds EXECUTE while high
//   InstrReady  out  high only in IDLE
//   S           out  ALU result-mux select
//   Binvert     out  invert ALU B operand
//   CarryIn     out  ALU adder carry-in
//   AluSrc      out  B operand is zero-extended Imm
//   RsAddr      out  captured rs field
//   RtAddr      out  captured rt field
//   RegDst      out  captured rd field
//   Imm         out  captured immediate
//   RegWrite    out  register-file write strobe (WRITEBACK only)
//   Illegal     out  last accepted opcode was undefined
//   Busy        out  state is not IDLE
//   InstrCount  out  completed legal instructions, wraps at 16 bits
module alu_control_fsm (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InstrValid,
  input  logic [23:0] Instr,
  input  logic        Stall,
  output logic        InstrReady,
  output logic [2:0]  S,
  output logic        Binvert,
  output logic        CarryIn,
  output logic        AluSrc,
  output logic [3:0]  RsAddr,
  output logic [3:0]  RtAddr,
  output logic [3:0]  RegDst,
  output logic [7:0]  Imm,
  output logic        RegWrite,
  output logic        Illegal,
  output logic        Busy,
  output logic [15:0] InstrCount
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [23:0] instr_q;
  logic        illegal_q;
  logic [15:0] count_q;
  logic        transfer;

  logic [3:0]  opcode;
  logic [2:0]  dec_s;
  logic        dec_binv;
  logic        dec_cin;
  logic        dec_src;
  logic        dec_writes;
  logic        dec_legal;

  assign transfer = InstrValid && (state == ST_IDLE);
  assign opcode   = instr_q[23:20];

  // Opcode decode of the captured instruction; undefined opcodes leave
  // every control at zero and are flagged through dec_legal.
  always_comb begin
    dec_s      = 3'b000;
    dec_binv   = 1'b0;
    dec_cin    = 1'b0;
    dec_src    = 1'b0;
    dec_writes = 1'b0;
    dec_legal  = 1'b1;
    case (opcode)
      4'b0000: begin dec_s = 3'b000; dec_writes = 1'b1; end
      4'b0001: begin dec_s = 3'b010; dec_writes = 1'b1; end
      4'b0010: begin dec_s = 3'b001; dec_writes = 1'b1; end
      4'b0011: begin dec_s = 3'b001; dec_binv = 1'b1; dec_cin = 1'b1; dec_writes = 1'b1; end
      4'b0100: begin dec_s = 3'b011; dec_writes = 1'b1; end
      4'b0101: begin dec_s = 3'b110; dec_binv = 1'b1; dec_cin = 1'b1; dec_writes = 1'b1; end
      4'b0110: begin dec_s = 3'b111; dec_writes = 1'b1; end
      4'b0111: begin dec_s = 3'b000; end
      4'b1000: begin dec_s = 3'b001; dec_src = 1'b1; dec_writes = 1'b1; end
      default: begin dec_legal = 1'b0; end
    endcase
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Captured instruction, illegal flag and completion counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      instr_q   <= 24'h000000;
      illegal_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      if (transfer) begin
        instr_q   <= Instr;
        illegal_q <= 1'b0;
      end
      if ((state == ST_DECODE) && !dec_legal) begin
        illegal_q <= 1'b1;
      end
      // NOP completes through WRITEBACK too, so it is counted here.
      if (state == ST_WRITEBACK) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (InstrValid) state_nxt = ST_DECODE;
      ST_DECODE:    state_nxt = dec_legal ? ST_EXECUTE : ST_IDLE;
      ST_EXECUTE:   if (!Stall) state_nxt = ST_WRITEBACK;
      ST_WRITEBACK: state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Outputs depend only on state and captured registers.
  always_comb begin
    InstrReady = (state == ST_IDLE);
    Busy       = (state != ST_IDLE);
    S          = 3'b000;
    Binvert    = 1'b0;
    CarryIn    = 1'b0;
    AluSrc     = 1'b0;
    RegWrite   = 1'b0;
    if ((state == ST_EXECUTE) || (state == ST_WRITEBACK)) begin
      S       = dec_s;
      Binvert = dec_binv;
      CarryIn = dec_cin;
      AluSrc  = dec_src;
    end
    if (state == ST_WRITEBACK) begin
      RegWrite = dec_writes;
    end
    RsAddr     = instr_q[19:16];
    RtAddr     = instr_q[15:12];
    RegDst     = instr_q[11:8];
    Imm        = instr_q[7:0];
    Illegal    = illegal_q;
    InstrCount = count_q;
  end

endmodule

// File: tb/tb_alu_control_fsm.sv
// tb/tb_alu_control_fsm.sv - self-checking bench for alu_control_fsm
module tb_alu_control_fsm;

  logic        Clock;
  logic        Reset;
  logic        InstrValid;
  logic [23:0] Instr;
  logic        Stall;
  logic        InstrReady;
  logic [2:0]  S;
  logic        Binvert;
  logic        CarryIn;
  logic        AluSrc;
  logic [3:0]  RsAddr;
  logic [3:0]  RtAddr;
  logic [3:0]  RegDst;
  logic [7:0]  Imm;
  logic        RegWrite;
  logic        Illegal;
  logic        Busy;
  logic [15:0] InstrCount;

  int tests = 0;
  int fails = 0;

  alu_control_fsm dut (
    .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid), .Instr(Instr), .Stall(Stall),
    .InstrReady(InstrReady), .S(S), .Binvert(Binvert), .CarryIn(CarryIn), .AluSrc(AluSrc),
    .RsAddr(RsAddr), .RtAddr(RtAddr), .RegDst(RegDst), .Imm(Imm), .RegWrite(RegWrite),
    .Illegal(Illegal), .Busy(Busy), .InstrCount(InstrCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    bit       legal;
    bit [2:0] s;
    bit       binv;
    bit       cin;
    bit       src;
    bit       writes;
  } dec_t;

  // Decode table written straight from the opcode list.
  function automatic dec_t ref_dec(input logic [3:0] op);
    dec_t d;
    d = '{legal: 1'b0, s: 3'b000, binv: 1'b0, cin: 1'b0, src: 1'b0, writes: 1'b0};
    case (op)
      4'h0: d = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
      4'h1: d = '{1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
      4'h2: d = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1};
      4'h3: d = '{1'b1, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1};
      4'h4: d = '{1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1};
      4'h5: d = '{1'b1, 3'b110, 1'b1, 1'b1, 1'b0, 1'b1};
      4'h6: d = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1};
      4'h7: d = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
      4'h8: d = '{1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
      default: ;
    endcase
    return d;
  endfunction

  // Expected values for the cycle currently being observed.
  logic        e_ready, e_busy, e_binv, e_cin, e_src, e_rw, e_ill;
  logic [2:0]  e_s;
  logic [3:0]  e_rs, e_rt, e_rd;
  logic [7:0]  e_imm;
  logic [15:0] e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".InstrReady"}, 32'(InstrReady), 32'(e_ready));
    chk({tag, ".Busy"},       32'(Busy),       32'(e_busy));
    chk({tag, ".S"},          32'(S),          32'(e_s));
    chk({tag, ".Binvert"},    32'(Binvert),    32'(e_binv));
    chk({tag, ".CarryIn"},    32'(CarryIn),    32'(e_cin));
    chk({tag, ".AluSrc"},     32'(AluSrc),     32'(e_src));
    chk({tag, ".RegWrite"},   32'(RegWrite),   32'(e_rw));
    chk({tag, ".Illegal"},    32'(Illegal),    32'(e_ill));
    chk({tag, ".InstrCount"}, 32'(InstrCount), 32'(e_cnt));
    chk({tag, ".RsAddr"},     32'(RsAddr),     32'(e_rs));
    chk({tag, ".RtAddr"},     32'(RtAddr),     32'(e_rt));
    chk({tag, ".RegDst"},     32'(RegDst),     32'(e_rd));
    chk({tag, ".Imm"},        32'(Imm),        32'(e_imm));
  endtask

  task automatic expect_idle();
    e_ready = 1'b1; e_busy = 1'b0;
    e_s = 3'b000; e_binv = 1'b0; e_cin = 1'b0; e_src = 1'b0; e_rw = 1'b0;
  endtask

  task automatic model_reset();
    expect_idle();
    e_ill = 1'b0; e_cnt = 16'h0000;
    e_rs = 4'h0; e_rt = 4'h0; e_rd = 4'h0; e_imm = 8'h00;
  endtask

  // Issues one instruction from IDLE and checks every cycle until it is
  // back in IDLE. While busy, InstrValid/Instr carry junk that must be ignored.
  task automatic run_instr(input logic [23:0] word, input int nstall, input string tag);
    dec_t d;
    d = ref_dec(word[23:20]);
    expect_idle();
    check_outputs({tag, "/idle"});
    InstrValid = 1'b1;
    Instr      = word;
    Stall      = 1'($urandom);
    @(negedge Clock);
    e_ready = 1'b0; e_busy = 1'b1; e_ill = 1'b0;
    e_rs = word[19:16]; e_rt = word[15:12]; e_rd = word[11:8]; e_imm = word[7:0];
    check_outputs({tag, "/decode"});
    InstrValid = 1'($urandom);
    Instr      = 24'($urandom);
    Stall      = 1'($urandom);
    @(negedge Clock);
    if (!d.legal) begin
      e_ill = 1'b1;
      expect_idle();
      check_outputs({tag, "/illegal"});
    end else begin
      e_s = d.s; e_binv = d.binv; e_cin = d.cin; e_src = d.src;
      for (int i = 0; i <= nstall; i++) begin
        check_outputs({tag, "/exec"});
        Stall      = (i < nstall);
        InstrValid = 1'($urandom);
        Instr      = 24'($urandom);
        @(negedge Clock);
      end
      e_rw = d.writes;
      check_outputs({tag, "/wb"});
      Stall      = 1'($urandom);
      InstrValid = 1'($urandom);
      Instr      = 24'($urandom);
      @(negedge Clock);
      e_cnt = e_cnt + 16'd1;
      expect_idle();
      check_outputs({tag, "/done"});
    end
    InstrValid = 1'b0;
    Stall      = 1'($urandom);
  endtask

  initial begin
    Reset = 1'b1; InstrValid = 1'b0; Instr = 24'h0; Stall = 1'b0;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    check_outputs("reset");
    Reset = 1'b0;
    @(negedge Clock);
    check_outputs("post_reset");

    // SUB r3 = r1 - r2
    run_instr(24'h312300, 0, "sub");
    // ADDI with five stall cycles
    run_instr(24'h8_4_0_7_5A, 5, "addi_stall");
    // Undefined opcode, then a legal AND clears Illegal
    run_instr(24'hC_1_2_3_44, 0, "illegal");
    run_instr(24'h0_5_6_7_11, 2, "and_after_ill");

    // Counter wrap on a NOP: preload the count register
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    e_cnt = 16'hFFFF;
    run_instr(24'h7_1_1_1_00, 1, "nop_wrap");

    // Reset mid-EXECUTE with Stall held high
    expect_idle();
    InstrValid = 1'b1; Instr = 24'h8_2_3_4_99; Stall = 1'b1;
    @(negedge Clock);
    InstrValid = 1'b1; Instr = 24'h2_F_F_F_FF;
    @(negedge Clock);
    @(negedge Clock);
    e_ready = 1'b0; e_busy = 1'b1; e_ill = 1'b0;
    e_rs = 4'h2; e_rt = 4'h3; e_rd = 4'h4; e_imm = 8'h99;
    e_s = 3'b001; e_src = 1'b1;
    check_outputs("rst_exec");
    Reset = 1'b1; InstrValid = 1'b1; Instr = 24'h3_A_B_C_DD;
    @(negedge Clock);
    model_reset();
    check_outputs("rst_from_exec");
    // Transfer offered together with Reset is discarded
    @(negedge Clock);
    check_outputs("rst_with_transfer");
    Reset = 1'b0; InstrValid = 1'b0; Stall = 1'b0;
    @(negedge Clock);
    check_outputs("rst_release");

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [23:0] w;
      w = 24'($urandom);
      w[23:20] = 4'($urandom_range(0, 15));
      run_instr(w, int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge Clock);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
